// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back path.
package regfile_pkg;

    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    // One pending register write: destination register and its data.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage : regfile_pkg

// File: rtl/wb_fifo.sv
// Dual-push, single-pop ring buffer of write-back entries.
// push0 is the older request: it lands at the write pointer, and push1 lands
// right behind it. The caller guarantees there is room for every push.
// The whole entry array and its valid mask are exported so the parent can
// search pending writes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push0_i,
    input  wb_entry_t                  push0_entry_i,
    input  logic                       push1_i,
    input  wb_entry_t                  push1_entry_i,
    input  logic                       pop_i,
    output wb_entry_t [DEPTH-1:0]      entries_o,
    output logic [DEPTH-1:0]           valid_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot1;

    // push1 sits behind push0 when both arrive together, otherwise at the tail.
    assign slot1 = push0_i ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

    // Pointer and occupancy arithmetic; pointers wrap naturally (DEPTH is 2^PW).
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end

    // Pointer and count registers; reset discards everything pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            wb_entry_t     slot_q;
            logic [PW-1:0] age;

            // Slot storage: loaded only by a push that targets this slot.
            always_ff @(posedge clk) begin
                if (push0_i && (wr_ptr_q == PW'(gi))) begin
                    slot_q <= push0_entry_i;
                end else if (push1_i && (slot1 == PW'(gi))) begin
                    slot_q <= push1_entry_i;
                end
            end

            // Distance from the head decides whether this slot is occupied.
            assign age          = PW'(gi) - rd_ptr_q;
            assign valid_o[gi]  = ({1'b0, age} < count_q);
            assign entries_o[gi] = slot_q;
        end
    endgenerate

    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule : wb_fifo

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file's single write port.
// Accepts ALU (in0, older) and load (in1, younger) write requests, drains one
// per cycle, and answers two lookups over the pending entries.
// Build option: WB_BYPASS_EN -- when defined, q_data1/q_data2 return the
// youngest pending data; otherwise only the hit flags are produced and the
// data outputs are 0.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in0_valid,
    output logic                    in0_ready,
    input  logic [AW-1:0]           in0_addr,
    input  logic [XLEN-1:0]         in0_data,
    input  logic                    in1_valid,
    output logic                    in1_ready,
    input  logic [AW-1:0]           in1_addr,
    input  logic [XLEN-1:0]         in1_data,
    output logic                    RegWrite,
    output logic [AW-1:0]           wa3,
    output logic [XLEN-1:0]         Writedata,
    input  logic [AW-1:0]           q_addr1,
    input  logic [AW-1:0]           q_addr2,
    output logic                    q_hit1,
    output logic                    q_hit2,
    output logic [XLEN-1:0]         q_data1,
    output logic [XLEN-1:0]         q_data2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] entries_w;
    logic [DEPTH-1:0]      valid_w;
    logic [PW-1:0]         rd_ptr_w;
    logic [CW-1:0]         count_w;
    logic                  accept0, accept1;
    logic                  not_empty;
    wb_entry_t             head_w;
    logic [AW-1:0]         last_addr_q;
    logic [XLEN-1:0]       last_data_q;

    // Ready is a function of the registered count only; in1 needs two free
    // slots because in0 may take one in the same cycle.
    assign in0_ready = !reset && (count_w < CW'(DEPTH));
    assign in1_ready = !reset && (count_w < CW'(DEPTH - 1));
    assign accept0   = in0_valid && in0_ready;
    assign accept1   = in1_valid && in1_ready;

    assign not_empty = (count_w != '0);
    assign RegWrite  = not_empty && !reset;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push0_i       (accept0),
        .push0_entry_i ({in0_addr, in0_data}),
        .push1_i       (accept1),
        .push1_entry_i ({in1_addr, in1_data}),
        .pop_i         (RegWrite),
        .entries_o     (entries_w),
        .valid_o       (valid_w),
        .rd_ptr_o      (rd_ptr_w),
        .count_o       (count_w)
    );

    assign head_w = entries_w[rd_ptr_w];

    // Remember the last drained entry so the write port holds steady when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr_q <= '0;
            last_data_q <= '0;
        end else if (RegWrite) begin
            last_addr_q <= head_w.addr;
            last_data_q <= head_w.data;
        end
    end

    assign wa3       = not_empty ? head_w.addr : last_addr_q;
    assign Writedata = not_empty ? head_w.data : last_data_q;
    assign count     = count_w;

`ifdef WB_BYPASS_EN
    // Lookup walking from head (oldest) to tail so the youngest match wins.
    always_comb begin
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        for (int age = 0; age < DEPTH; age++) begin
            if (valid_w[rd_ptr_w + PW'(age)] &&
                (entries_w[rd_ptr_w + PW'(age)].addr == q_addr1)) begin
                q_hit1  = 1'b1;
                q_data1 = entries_w[rd_ptr_w + PW'(age)].data;
            end
            if (valid_w[rd_ptr_w + PW'(age)] &&
                (entries_w[rd_ptr_w + PW'(age)].addr == q_addr2)) begin
                q_hit2  = 1'b1;
                q_data2 = entries_w[rd_ptr_w + PW'(age)].data;
            end
        end
    end
`else
    // Scoreboard-only lookup: any pending entry to the address is a hit.
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_w[i] && (entries_w[i].addr == q_addr1)) q_hit1 = 1'b1;
            if (valid_w[i] && (entries_w[i].addr == q_addr2)) q_hit2 = 1'b1;
        end
    end

    assign q_data1 = '0;
    assign q_data2 = '0;
`endif

endmodule : regfile_wb_queue

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in0_valid, in0_ready;
    logic [4:0]  in0_addr;
    logic [63:0] in0_data;
    logic        in1_valid, in1_ready;
    logic [4:0]  in1_addr;
    logic [63:0] in1_data;
    logic        RegWrite;
    logic [4:0]  wa3;
    logic [63:0] Writedata;
    logic [4:0]  q_addr1, q_addr2;
    logic        q_hit1, q_hit2;
    logic [63:0] q_data1, q_data2;
    logic [2:0]  count;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_addr  (in0_addr),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_addr  (in1_addr),
        .in1_data  (in1_data),
        .RegWrite  (RegWrite),
        .wa3       (wa3),
        .Writedata (Writedata),
        .q_addr1   (q_addr1),
        .q_addr2   (q_addr2),
        .q_hit1    (q_hit1),
        .q_hit2    (q_hit2),
        .q_data1   (q_data1),
        .q_data2   (q_data2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending writes in program order, oldest at index 0.
    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [4:0]  last_a;
    logic [63:0] last_d;
    int          n_checks;
    int          n_fail;
    int          cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Youngest pending match for an address (data only with bypass enabled).
    task automatic lookup(input logic [4:0] qa, output logic hit, output logic [63:0] dat);
        hit = 1'b0;
        dat = '0;
        foreach (mq[i]) begin
            if (mq[i].a == qa) begin
                hit = 1'b1;
`ifdef WB_BYPASS_EN
                dat = mq[i].d;
`endif
            end
        end
    endtask

    // One clock cycle: drive, check outputs at negedge, advance model at posedge.
    task automatic step(input logic rst,
                        input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                        input logic [4:0] qa1, input logic [4:0] qa2);
        logic        er0, er1, ewr, eh1, eh2;
        logic [63:0] ed1, ed2;
        int          sz;
        ent_t        e;
        reset = rst;
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        q_addr1 = qa1;  q_addr2 = qa2;
        sz  = mq.size();
        er0 = !rst && (sz < DEPTH);
        er1 = !rst && (sz < DEPTH - 1);
        ewr = !rst && (sz != 0);
        lookup(qa1, eh1, ed1);
        lookup(qa2, eh2, ed2);
        @(negedge clk);
        check("count", 64'(count), 64'(sz));
        check("in0_ready", 64'(in0_ready), 64'(er0));
        check("in1_ready", 64'(in1_ready), 64'(er1));
        check("RegWrite", 64'(RegWrite), 64'(ewr));
        check("q_hit1", 64'(q_hit1), 64'(eh1));
        check("q_hit2", 64'(q_hit2), 64'(eh2));
        check("q_data1", q_data1, ed1);
        check("q_data2", q_data2, ed2);
        if (ewr) begin
            check("wa3", 64'(wa3), 64'(mq[0].a));
            check("Writedata", Writedata, mq[0].d);
            $display("cycle %0d: write r%0d <= %h (count %0d)", cyc, wa3, Writedata, count);
        end else if (!rst) begin
            check("wa3_hold", 64'(wa3), 64'(last_a));
            check("Writedata_hold", Writedata, last_d);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            last_a = '0;
            last_d = '0;
        end else begin
            if (ewr) begin
                e = mq.pop_front();
                last_a = e.a;
                last_d = e.d;
            end
            if (v0 && er0) mq.push_back('{a0, d0});
            if (v1 && er1) mq.push_back('{a1, d1});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input logic [4:0] qa1, input logic [4:0] qa2);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, qa1, qa2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last_a   = '0;
        last_d   = '0;
        reset = 1'b1;
        in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
        in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
        q_addr1 = '0; q_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Checked reset cycle, then reset-state idle.
        step(1'b1, 1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 5'd1, 5'd2);
        idle(5'd3, 5'd0);

        // Single write to r3, drained next cycle.
        step(1'b0, 1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0, 5'd3, 5'd0);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);

        // Same-cycle pair to r5: ordered drain, youngest lookup.
        step(1'b0, 1'b1, 5'd5, 64'hA, 1'b1, 5'd5, 64'hB, 5'd5, 5'd4);
        idle(5'd5, 5'd4);
        idle(5'd5, 5'd4);
        idle(5'd5, 5'd4);

        // Saturate both inputs for 10 cycles, then drain.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 5'(i), {32'hA0A0_0000, 32'(i)},
                 1'b1, 5'(i + 16), {32'hB0B0_0000, 32'(i)}, 5'(i), 5'(i + 16));
        end
        repeat (6) idle(5'd16, 5'd3);

        // Build three entries, then reset with requests present: all dropped.
        step(1'b0, 1'b1, 5'd10, 64'h100, 1'b1, 5'd11, 64'h101, 5'd10, 5'd11);
        step(1'b0, 1'b1, 5'd12, 64'h102, 1'b1, 5'd13, 64'h103, 5'd12, 5'd13);
        step(1'b1, 1'b1, 5'd14, 64'h104, 1'b1, 5'd15, 64'h105, 5'd12, 5'd13);
        idle(5'd12, 5'd14);
        idle(5'd12, 5'd14);

        // Pending write to r7; lookup of r9 misses, r7 hits.
        step(1'b0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 5'd7, 5'd9);
        idle(5'd9, 5'd7);
        idle(5'd9, 5'd7);

        // Register 0 is queued like any other.
        step(1'b0, 1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (6) idle(5'd1, 5'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_queue
